uart_tx_sched: RTL and testbench

Transmit scheduler that drains the UART byte FIFO and serialises each byte onto the TX line as 8N1 (or 8N2) frames. It watches the FIFO head (have-next flag plus head byte) and issues one pop pulse per frame. It also generates bit timing from a fixed clock divider. It sits between the CSR-fed FIFO and the UART pad, and is the only block that drives the FIFO pop input.

---
 rtl/uart_tx_sched.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched
//  Purpose  : Drains the UART byte FIFO and serialises each byte as an 8N1/8N2
//             frame with fixed-divider bit timing and one pop pulse per frame.
//  Revision : 1.0
// ============================================================================
module uart_tx_sched #(
    parameter int BAUD_DIV    = 104,
    parameter int STOP_BITS   = 1,
    parameter int POP_SETTLE  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   have_next_i,
    input  logic [7:0]             data_i,
    output logic                   next_o,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic [COUNT_WIDTH-1:0] frame_count_o
);

    localparam int c_BAUD_W   = $clog2(BAUD_DIV);
    localparam int c_SETTLE_W = (POP_SETTLE < 1) ? 1 : $clog2(POP_SETTLE + 1);
    localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST   = c_BAUD_W'(BAUD_DIV - 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_INIT = c_SETTLE_W'(POP_SETTLE);
    localparam logic                  c_STOP_LAST   = 1'(STOP_BITS - 1);

    generate
        if (BAUD_DIV < 2) begin : g_bad_baud_div
            $error("uart_tx_sched: BAUD_DIV must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_sched: STOP_BITS must be 1 or 2");
        end
        if (10 * BAUD_DIV <= POP_SETTLE) begin : g_bad_pop_settle
            $error("uart_tx_sched: a frame must outlast POP_SETTLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                  r_state,    w_state_nx;
    logic [c_BAUD_W-1:0]     r_baud,     w_baud_nx;
    logic [2:0]              r_bit_idx,  w_bit_idx_nx;
    logic                    r_stop_idx, w_stop_idx_nx;
    logic [7:0]              r_shift,    w_shift_nx;
    logic [c_SETTLE_W-1:0]   r_settle,   w_settle_nx;
    logic                    r_tx,       w_tx_nx;
    logic                    r_next,     w_next_nx;
    logic                    r_busy,     w_busy_nx;
    logic [COUNT_WIDTH-1:0]  r_count,    w_count_nx;

    logic w_baud_last;
    logic w_can_pop;
    logic w_launch;

    assign w_baud_last = (r_baud == c_BAUD_LAST);
    // FIFO head is only trusted once the post-pop settle window has drained
    assign w_can_pop   = enable_i && have_next_i && (r_settle == '0);

    always_comb begin
        w_state_nx    = r_state;
        w_baud_nx     = r_baud;
        w_bit_idx_nx  = r_bit_idx;
        w_stop_idx_nx = r_stop_idx;
        w_shift_nx    = r_shift;
        w_settle_nx   = (r_settle != '0) ? r_settle - 1'b1 : r_settle;
        w_tx_nx       = r_tx;
        w_next_nx     = 1'b0;
        w_busy_nx     = r_busy;
        w_count_nx    = r_count;
        w_launch      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_tx_nx   = 1'b1;
                w_busy_nx = 1'b0;
                w_launch  = w_can_pop;
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_nx    = '0;
                    w_bit_idx_nx = 3'd0;
                    w_tx_nx      = r_shift[0];
                    w_state_nx   = S_DATA;
                end else begin
                    w_baud_nx = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nx = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_stop_idx_nx = 1'b0;
                        w_tx_nx       = 1'b1;
                        w_state_nx    = S_STOP;
                    end else begin
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                        w_bit_idx_nx = r_bit_idx + 1'b1;
                        w_tx_nx      = r_shift[1];
                    end
                end else begin
                    w_baud_nx = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_nx = '0;
                    if (r_stop_idx == c_STOP_LAST) begin
                        w_count_nx = r_count + 1'b1;
                        if (w_can_pop) begin
                            w_launch = 1'b1;
                        end else begin
                            w_tx_nx    = 1'b1;
                            w_busy_nx  = 1'b0;
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_stop_idx_nx = r_stop_idx + 1'b1;
                    end
                end else begin
                    w_baud_nx = r_baud + 1'b1;
                end
            end
        endcase

        // Start bit and pop pulse leave on the same edge, from IDLE or straight out of STOP
        if (w_launch) begin
            w_shift_nx  = data_i;
            w_next_nx   = 1'b1;
            w_tx_nx     = 1'b0;
            w_busy_nx   = 1'b1;
            w_baud_nx   = '0;
            w_settle_nx = c_SETTLE_INIT;
            w_state_nx  = S_START;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= 8'd0;
            r_settle   <= '0;
            r_tx       <= 1'b1;
            r_next     <= 1'b0;
            r_busy     <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_baud     <= w_baud_nx;
            r_bit_idx  <= w_bit_idx_nx;
            r_stop_idx <= w_stop_idx_nx;
            r_shift    <= w_shift_nx;
            r_settle   <= w_settle_nx;
            r_tx       <= w_tx_nx;
            r_next     <= w_next_nx;
            r_busy     <= w_busy_nx;
            r_count    <= w_count_nx;
        end
    end

    assign next_o        = r_next;
    assign tx_o          = r_tx;
    assign busy_o        = r_busy;
    assign frame_count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_sched
//  Purpose  : Three scheduler instances (8N1, 8N2, 2-bit counter) driven by a
//             FIFO model and checked every cycle against a frame-level model.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx_sched;

    localparam int BD = 4;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_r, en_r, hn_r;
    logic [7:0]    dat_r [NI];
    logic [NI-1:0] nxt_w, tx_w, busy_w;
    logic [15:0]   cnt0, cnt1;
    logic [1:0]    cnt2;

    uart_tx_sched #(.BAUD_DIV(BD), .STOP_BITS(1), .POP_SETTLE(4), .COUNT_WIDTH(16)) u_dut0 (
        .clk_i(clk), .reset_i(rst_r[0]), .enable_i(en_r[0]), .have_next_i(hn_r[0]),
        .data_i(dat_r[0]), .next_o(nxt_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]),
        .frame_count_o(cnt0));
    uart_tx_sched #(.BAUD_DIV(BD), .STOP_BITS(2), .POP_SETTLE(4), .COUNT_WIDTH(16)) u_dut1 (
        .clk_i(clk), .reset_i(rst_r[1]), .enable_i(en_r[1]), .have_next_i(hn_r[1]),
        .data_i(dat_r[1]), .next_o(nxt_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]),
        .frame_count_o(cnt1));
    uart_tx_sched #(.BAUD_DIV(BD), .STOP_BITS(1), .POP_SETTLE(4), .COUNT_WIDTH(2)) u_dut2 (
        .clk_i(clk), .reset_i(rst_r[2]), .enable_i(en_r[2]), .have_next_i(hn_r[2]),
        .data_i(dat_r[2]), .next_o(nxt_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]),
        .frame_count_o(cnt2));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Frame-level model: a frame is just "byte + cycles since the start bit fell"
    logic          m_act  [NI];
    int            m_off  [NI];
    logic [7:0]    m_byte [NI];
    logic [15:0]   m_cnt  [NI];
    logic [NI-1:0] e_tx, e_nxt, e_busy;

    // FIFO model: head is re-presented three cycles after each pop
    logic [7:0] fbuf [NI][256];
    int         frd  [NI];
    int         fwr  [NI];
    int         fgap [NI];

    int   s_next [NI];
    int   s_busy [NI];
    int   s_txlow[NI];
    int   last_pop [NI];
    int   rst_hold [NI];
    logic rec_wrap = 1'b0;
    int   wrap_n   = 0;
    logic [1:0] wrap_log [8];
    logic [1:0] prev_cnt2 = 2'd0;

    function automatic int stop_bits(int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic logic [15:0] cnt_mask(int i);
        return (i == 2) ? 16'h0003 : 16'hFFFF;
    endfunction

    function automatic logic [15:0] dut_cnt(int i);
        case (i)
            0:       return cnt0;
            1:       return cnt1;
            default: return {14'd0, cnt2};
        endcase
    endfunction

    function automatic logic line_level(logic [7:0] b, int off);
        int slot;
        slot = off / BD;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic check(string name, int i, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
    endtask

    task automatic model_edge(int i);
        int len;
        len = (9 + stop_bits(i)) * BD;
        e_nxt[i] = 1'b0;
        if (rst_r[i]) begin
            m_act[i] = 1'b0;
            m_cnt[i] = 16'd0;
        end else begin
            if (m_act[i]) begin
                m_off[i]++;
                if (m_off[i] == len) begin
                    m_act[i] = 1'b0;
                    m_cnt[i] = (m_cnt[i] + 16'd1) & cnt_mask(i);
                end
            end
            if (!m_act[i] && en_r[i] && hn_r[i]) begin
                m_act[i]  = 1'b1;
                m_off[i]  = 0;
                m_byte[i] = dat_r[i];
                e_nxt[i]  = 1'b1;
            end
        end
        e_busy[i] = m_act[i];
        e_tx[i]   = m_act[i] ? line_level(m_byte[i], m_off[i]) : 1'b1;
    endtask

    task automatic fifo_drive(int i);
        if (nxt_w[i]) begin
            if (frd[i] < fwr[i]) frd[i]++;
            fgap[i] = 3;
        end else if (fgap[i] > 0) begin
            fgap[i]--;
        end
        if (fgap[i] > 0) begin
            hn_r[i]  = 1'b1;
            dat_r[i] = 8'($urandom);
        end else if (frd[i] < fwr[i]) begin
            hn_r[i]  = 1'b1;
            dat_r[i] = fbuf[i][frd[i] % 256];
        end else begin
            hn_r[i]  = 1'b0;
            dat_r[i] = 8'($urandom);
        end
    endtask

    task automatic push(int i, logic [7:0] b);
        fbuf[i][fwr[i] % 256] = b;
        fwr[i]++;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NI; i++) begin
            s_next[i] = 0; s_busy[i] = 0; s_txlow[i] = 0;
        end
    endtask

    task automatic step();
        for (int i = 0; i < NI; i++) model_edge(i);
        @(posedge clk);
        #2;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            check("tx_o",          i, 64'(tx_w[i]),     64'(e_tx[i]));
            check("next_o",        i, 64'(nxt_w[i]),    64'(e_nxt[i]));
            check("busy_o",        i, 64'(busy_w[i]),   64'(e_busy[i]));
            check("frame_count_o", i, 64'(dut_cnt(i)),  64'(m_cnt[i]));
            if (nxt_w[i]) begin s_next[i]++; last_pop[i] = cyc; end
            if (busy_w[i]) s_busy[i]++;
            if (!tx_w[i]) s_txlow[i]++;
            fifo_drive(i);
        end
        if (rec_wrap && cnt2 != prev_cnt2 && wrap_n < 8) begin
            wrap_log[wrap_n] = cnt2;
            wrap_n++;
        end
        prev_cnt2 = cnt2;
    endtask

    task automatic wait_pop(int i, int lim, string name);
        int g;
        g = 0;
        while (!nxt_w[i] && g < lim) begin step(); g++; end
        check(name, i, 64'(nxt_w[i]), 64'd1);
    endtask

    logic [39:0] wave0;
    logic [43:0] wave1;
    logic [80:0] wave_bb;
    logic [9:0]  a5_lv = 10'b1101001010;
    logic [39:0] a5_exp;
    logic [1:0]  wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int          p1;

    initial begin
        rst_r = '1; en_r = '0; hn_r = '0;
        for (int i = 0; i < NI; i++) begin
            dat_r[i] = 8'd0; m_act[i] = 1'b0; m_off[i] = 0; m_byte[i] = 8'd0;
            m_cnt[i] = 16'd0; frd[i] = 0; fwr[i] = 0; fgap[i] = 0;
            last_pop[i] = 0; rst_hold[i] = 0;
        end
        e_tx = '1; e_nxt = '0; e_busy = '0;
        clear_stats();

        // Reset, then 20 quiet cycles with nothing queued
        repeat (3) step();
        rst_r = '0;
        en_r  = '1;
        clear_stats();
        repeat (20) step();
        check("rst_tx_low_cycles", 0, 64'(s_txlow[0]), 64'd0);
        check("rst_pops",          0, 64'(s_next[0]),  64'd0);
        check("rst_busy_cycles",   0, 64'(s_busy[0]),  64'd0);
        check("rst_count",         0, 64'(dut_cnt(0)), 64'd0);

        // Single 0xA5 frame
        clear_stats();
        push(0, 8'hA5);
        wait_pop(0, 20, "a5_pop_seen");
        wave0[0] = tx_w[0];
        for (int j = 1; j < 40; j++) begin step(); wave0[j] = tx_w[0]; end
        repeat (20) step();
        for (int j = 0; j < 40; j++) a5_exp[j] = a5_lv[j / 4];
        check("a5_wave",        0, 64'(wave0),      64'(a5_exp));
        check("a5_pops",        0, 64'(s_next[0]),  64'd1);
        check("a5_busy_cycles", 0, 64'(s_busy[0]),  64'd40);
        check("a5_count",       0, 64'(dut_cnt(0)), 64'd1);

        // 8N2 frame of 0x80 on the second instance
        clear_stats();
        push(1, 8'h80);
        wait_pop(1, 20, "x80_pop_seen");
        wave1[0] = tx_w[1];
        for (int j = 1; j < 44; j++) begin step(); wave1[j] = tx_w[1]; end
        repeat (20) step();
        check("x80_low_part",    1, 64'(wave1[31:0]),  64'd0);
        check("x80_high_part",   1, 64'(wave1[43:32]), 64'hFFF);
        check("x80_busy_cycles", 1, 64'(s_busy[1]),    64'd44);

        // Back-to-back 0x00, 0xFF
        clear_stats();
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_pop(0, 20, "bb_pop_seen");
        p1 = cyc;
        wave_bb[0] = tx_w[0];
        for (int j = 1; j < 81; j++) begin step(); wave_bb[j] = tx_w[0]; end
        repeat (20) step();
        check("bb_pops",        0, 64'(s_next[0]),        64'd2);
        check("bb_pop_spacing", 0, 64'(last_pop[0] - p1), 64'd40);
        check("bb_last_stop",   0, 64'(wave_bb[39]),      64'd1);
        check("bb_next_start",  0, 64'(wave_bb[40]),      64'd0);
        check("bb_busy_cycles", 0, 64'(s_busy[0]),        64'd80);
        check("bb_count",       0, 64'(dut_cnt(0)),       64'd3);

        // Enable gating
        en_r[0] = 1'b0;
        push(0, 8'h3C);
        clear_stats();
        repeat (50) step();
        check("gate_pops",       0, 64'(s_next[0]),  64'd0);
        check("gate_tx_low",     0, 64'(s_txlow[0]), 64'd0);
        en_r[0] = 1'b1;
        clear_stats();
        wait_pop(0, 5, "gate_pop_seen");
        repeat (10) step();
        en_r[0] = 1'b0;
        push(0, 8'h11);
        repeat (70) step();
        check("gate_single_pop", 0, 64'(s_next[0]),  64'd1);
        check("gate_busy",       0, 64'(s_busy[0]),  64'd40);
        check("gate_count",      0, 64'(dut_cnt(0)), 64'd4);
        en_r[0] = 1'b1;
        wait_pop(0, 5, "resume_pop_seen");
        repeat (45) step();
        check("resume_count",    0, 64'(dut_cnt(0)), 64'd5);

        // Reset during data bit 3 of 0x5A
        push(0, 8'h5A);
        wait_pop(0, 20, "mid_pop_seen");
        repeat (17) step();
        clear_stats();
        rst_r[0] = 1'b1;
        step();
        check("mid_rst_tx",    0, 64'(tx_w[0]),    64'd1);
        check("mid_rst_busy",  0, 64'(busy_w[0]),  64'd0);
        check("mid_rst_count", 0, 64'(dut_cnt(0)), 64'd0);
        repeat (3) step();
        check("mid_rst_pops",  0, 64'(s_next[0]),  64'd0);
        rst_r[0] = 1'b0;
        repeat (10) step();

        // Counter wrap on the 2-bit instance
        for (int k = 0; k < 5; k++) push(2, 8'($urandom));
        rec_wrap = 1'b1;
        for (int g = 0; g < 300 && wrap_n < 5; g++) step();
        rec_wrap = 1'b0;
        check("wrap_events", 2, 64'(wrap_n), 64'd5);
        for (int k = 0; k < 5; k++) check("wrap_value", 2, 64'(wrap_log[k]), 64'(wrap_exp[k]));

        // Randomised traffic, enable toggling and occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 29) == 0 && (fwr[i] - frd[i]) < 8) push(i, 8'($urandom));
                if ($urandom_range(0, 199) == 0) en_r[i] = ~en_r[i];
                if (rst_hold[i] > 0) begin
                    rst_hold[i]--;
                    if (rst_hold[i] == 0) rst_r[i] = 1'b0;
                end else if ($urandom_range(0, 799) == 0) begin
                    rst_r[i] = 1'b1;
                    rst_hold[i] = 4;
                end
            end
            step();
        end
        rst_r = '0;
        en_r  = '0;
        repeat (60) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
